// File: rtl/log_arith_pkg.sv
// rtl/log_arith_pkg.sv - shared constants, state encodings and round-robin helpers
package log_arith_pkg;
   localparam int W_DEF  = 8;
   localparam int RR_MAX = 32;
   localparam int RR_IDW = 5;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // First valid index at or after ptr, wrapping at n; n must not exceed RR_MAX.
   function automatic logic [RR_IDW-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                 input logic [RR_IDW-1:0] ptr,
                                                 input int n);
      logic [RR_IDW-1:0] pick;
      logic              found;
      logic [31:0]       idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < RR_MAX; k++) begin
         idx = 32'(ptr) + 32'(k);
         if (idx >= 32'(n)) idx = idx - 32'(n);
         if (!found && (k < n) && valid[idx[RR_IDW-1:0]]) begin
            pick  = idx[RR_IDW-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction
endpackage

// File: rtl/log_arith_unit.sv
// rtl/log_arith_unit.sv - combinational logic/arithmetic unit, all results modulo 2^W
module log_arith_unit #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] w,
   output logic [W-1:0] x,
   output logic [W-1:0] y,
   output logic [W-1:0] z
);
   logic [W-1:0] w_sum_bc;
   logic [W-1:0] w_and_ac;
   logic [W-1:0] w_not_a;
   logic [W-1:0] w_sum_nac;

   assign w_sum_bc  = b + c;
   assign w_and_ac  = a & c;
   assign w_not_a   = ~a;
   assign w_sum_nac = w_not_a + c;

   assign w = w_sum_bc | a;
   assign x = w_and_ac + b;
   assign y = w_sum_nac & b;
   assign z = (b | c) & a;
endmodule

// File: rtl/log_arith_sched.sv
// rtl/log_arith_sched.sv - round-robin scheduler sharing one log_arith_unit among N_REQ requesters
module log_arith_sched
   import log_arith_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = W_DEF,
   localparam int IDW  = id_width(N_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   input  logic [N_REQ*W-1:0] req_c,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [W-1:0]       rsp_w,
   output logic [W-1:0]       rsp_x,
   output logic [W-1:0]       rsp_y,
   output logic [W-1:0]       rsp_z,
   output logic               busy
);
   logic [1:0]       r_state;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   r_gnt_id;
   logic [W-1:0]     r_a, r_b, r_c;
   logic [IDW-1:0]   r_rsp_id;
   logic [W-1:0]     r_w, r_x, r_y, r_z;

   logic             w_grant;
   logic [IDW-1:0]   w_pick;
   logic [N_REQ-1:0] w_req_ready;
   logic [W-1:0]     w_u_w, w_u_x, w_u_y, w_u_z;

   always_comb begin
      w_pick = IDW'(rr_pick(RR_MAX'(req_valid), RR_IDW'(r_rr_ptr), N_REQ));
   end

   // Reset gates the grant so a held-valid requester is never acknowledged while rst_n is low.
   assign w_grant = rst_n && (r_state == S_IDLE) && (|req_valid);

   always_comb begin
      w_req_ready = '0;
      if (w_grant) w_req_ready[w_pick] = 1'b1;
   end

   assign req_ready = w_req_ready;

   log_arith_unit #(.W(W)) u_unit (
      .a (r_a),
      .b (r_b),
      .c (r_c),
      .w (w_u_w),
      .x (w_u_x),
      .y (w_u_y),
      .z (w_u_z)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_gnt_id <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= '0;
         r_rsp_id <= '0;
         r_w      <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_z      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_a      <= req_a[w_pick*W +: W];
                  r_b      <= req_b[w_pick*W +: W];
                  r_c      <= req_c[w_pick*W +: W];
                  r_gnt_id <= w_pick;
                  r_state  <= S_CALC;
               end
            end
            S_CALC: begin
               r_w      <= w_u_w;
               r_x      <= w_u_x;
               r_y      <= w_u_y;
               r_z      <= w_u_z;
               r_rsp_id <= r_gnt_id;
               r_rr_ptr <= (r_gnt_id == IDW'(N_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
               r_state  <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = (r_state == S_RESP);
   assign rsp_id    = r_rsp_id;
   assign rsp_w     = r_w;
   assign rsp_x     = r_x;
   assign rsp_y     = r_y;
   assign rsp_z     = r_z;
   assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_log_arith_sched.sv
// tb/tb_log_arith_sched.sv - directed self-checking bench for log_arith_sched
module tb_log_arith_sched;
   localparam int N_REQ = 4;
   localparam int W     = 8;
   localparam int IDW   = 2;

   logic               clk;
   logic               rst_n;
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ*W-1:0] req_a, req_b, req_c;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [W-1:0]       rsp_w, rsp_x, rsp_y, rsp_z;
   logic               busy;

   int n_tests;
   int n_fail;

   log_arith_sched #(.N_REQ(N_REQ), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_w     (rsp_w),
      .rsp_x     (rsp_x),
      .rsp_y     (rsp_y),
      .rsp_z     (rsp_z),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_c[i*W +: W] = c;
   endtask

   function automatic logic [63:0] rsp_bundle();
      return {27'd0, rsp_valid, 2'd0, rsp_id, rsp_w, rsp_x, rsp_y, rsp_z};
   endfunction

   int            g_ids[$];
   int            g_cyc[$];
   int            r_ids[$];
   logic [63:0]   held;

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      req_c     = '0;
      rsp_ready = 1'b1;

      // Reset with every requester asking.
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_outputs", {rsp_id, rsp_w, rsp_x, rsp_y, rsp_z}, 0);

      tick();
      req_valid = '0;
      rst_n     = 1'b1;
      tick();

      // Single op from requester 0.
      set_req(0, 8'hFF, 8'h3F, 8'h1D);
      req_valid = 4'b0001;
      @(negedge clk);
      check("single_grant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("single_t1_valid", rsp_valid, 0);
      check("single_t1_busy", busy, 1);
      @(negedge clk);
      check("single_t2_valid", rsp_valid, 1);
      check("single_id", rsp_id, 0);
      check("single_wxyz", {rsp_w, rsp_x, rsp_y, rsp_z}, 32'hFF5C1D3F);
      @(negedge clk);
      check("single_idle", busy, 0);

      // Requester 2 alone; sums wrap to zero.
      tick();
      set_req(2, 8'h00, 8'hFF, 8'h01);
      req_valid = 4'b0100;
      @(negedge clk);
      check("wrap_grant", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      check("wrap_valid", rsp_valid, 1);
      check("wrap_id", rsp_id, 2);
      check("wrap_wxyz", {rsp_w, rsp_x, rsp_y, rsp_z}, 32'h00FF0000);

      // Fresh pointer, then all four continuously valid.
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      req_valid = 4'b1111;
      for (int cyc = 0; cyc < 18; cyc++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            for (int j = 0; j < N_REQ; j++) if (req_ready[j]) g_ids.push_back(j);
            g_cyc.push_back(cyc);
         end
         if (rsp_valid) r_ids.push_back(int'(rsp_id));
      end
      tick();
      req_valid = '0;
      check("fair_grant_count", g_ids.size(), 6);
      check("fair_rsp_count", r_ids.size(), 6);
      for (int k = 0; k < 6 && k < g_ids.size() && k < r_ids.size(); k++) begin
         check($sformatf("fair_gid%0d", k), g_ids[k], k % N_REQ);
         check($sformatf("fair_gcyc%0d", k), g_cyc[k], 3 * k);
         check($sformatf("fair_rid%0d", k), r_ids[k], k % N_REQ);
      end

      // Backpressure: pointer sits at 2, requester 3 is the only one asking.
      rsp_ready = 1'b0;
      set_req(3, 8'h0F, 8'hF0, 8'h33);
      req_valid = 4'b1000;
      @(negedge clk);
      check("bp_grant", req_ready, 4'b1000);
      tick();
      req_valid = 4'b0001;
      set_req(0, 8'h00, 8'h01, 8'h02);
      @(negedge clk);
      check("bp_calc_ready", req_ready, 0);
      @(negedge clk);
      check("bp_resp", rsp_bundle(), {27'd0, 1'b1, 2'd0, 2'd3, 32'h2FF32003});
      held = rsp_bundle();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d", k), rsp_bundle(), held);
         check($sformatf("bp_ready%0d", k), req_ready, 0);
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", rsp_valid, 1);
      @(negedge clk);
      check("bp_idle", busy, 0);
      check("bp_next_grant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      repeat (3) @(negedge clk);
      check("bp_drain", busy, 0);

      // Reset during CALC drops the op and clears the pointer.
      tick();
      req_valid = 4'b0100;
      @(negedge clk);
      check("mid_grant", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("mid_calc_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", rsp_valid, 0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("mid_no_rsp%0d", k), rsp_valid, 0);
      end
      tick();
      set_req(1, 8'h00, 8'h01, 8'h02);
      req_valid = 4'b0010;
      @(negedge clk);
      check("mid_after_grant", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      check("mid_after_valid", rsp_valid, 1);
      check("mid_after_id", rsp_id, 1);
      check("mid_after_wxyz", {rsp_w, rsp_x, rsp_y, rsp_z}, 32'h03010100);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
